// File: rtl/neuron_spike_out_buf.sv
// Spike frame buffer drained over Wishbone; SPIKE_OUT_IRQ_EN adds irq_o and CTRL bit2.
// Wishbone ack one cycle after request; spike_ready_o drops when full, frames arriving then are counted as drops.

module spike_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop_vld,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_do;
  logic             pop_do;

  assign full     = (count == DEPTH[$clog2(DEPTH+1)-1:0]);
  assign empty    = (count == '0);
  assign push_do  = push_vld & ~full;
  assign pop_do   = pop_vld & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + 1'b1;
      if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_do, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_do) mem[wr_ptr] <= push_dat;
  end
endmodule

module neuron_spike_out_buf #(
  parameter logic [31:0] BASE_ADDR   = 32'h30008000,
  parameter int          NUM_NEURONS = 256,
  parameter int          DEPTH       = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic                   spike_valid_i,
  input  logic [NUM_NEURONS-1:0] spike_data_i,
  output logic                   spike_ready_o
`ifdef SPIKE_OUT_IRQ_EN
  ,
  output logic                   irq_o
`endif
);
  localparam int NW = NUM_NEURONS / 32;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] drop_cnt;
    logic [4:0]  rsvd;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [7:0]  count;
  } status_t;

  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [NUM_NEURONS-1:0] head_dat;
  logic                   bus_req;
  logic                   ctrl_wr;
  logic                   pop_vld;
  logic                   clr_vld;
  logic                   push_vld;
  logic                   drop_vld;
  logic [31:0]            adr_off;
  logic [31:0]            word_off;
  logic [31:0]            rd_dat;
  logic                   overflow;
  logic [15:0]            drop_cnt;
  logic                   irq_en;
  status_t                status;
  logic                   unused_ok;

  assign bus_req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign adr_off       = wbs_adr_i - BASE_ADDR;
  assign word_off      = {2'b00, adr_off[31:2]};
  assign ctrl_wr       = bus_req & wbs_we_i & (word_off == 32'd1) & wbs_sel_i[0];
  assign pop_vld       = ctrl_wr & wbs_dat_i[0];
  assign clr_vld       = ctrl_wr & wbs_dat_i[1];
  assign spike_ready_o = ~fifo_full;
  assign push_vld      = spike_valid_i & spike_ready_o;
  assign drop_vld      = spike_valid_i & ~spike_ready_o;
  assign unused_ok     = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:2], adr_off[1:0]};

  spike_fifo #(
    .WIDTH (NUM_NEURONS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push_vld (push_vld),
    .push_dat (spike_data_i),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    status          = '0;
    status.drop_cnt = drop_cnt;
    status.overflow = overflow;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.count    = 8'(fifo_count);
  end

  always_comb begin
    rd_dat = 32'h0;
    if (word_off == 32'd0) begin
      rd_dat = status;
    end else if (word_off == 32'd1) begin
      rd_dat = {29'b0, irq_en, 2'b0};
    end else if (!fifo_empty) begin
      for (int k = 0; k < NW; k++) begin
        if (word_off == 32'(k + 2)) rd_dat = head_dat[32*k +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= bus_req;
      if (bus_req) wbs_dat_o <= rd_dat;
    end
  end

  // A clear issued on the same edge as a drop takes priority.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0;
    end else if (clr_vld) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0;
    end else if (drop_vld) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h1;
    end
  end

`ifdef SPIKE_OUT_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wbs_dat_i[2];
      irq_o <= irq_en & ((fifo_count != '0) | overflow);
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_neuron_spike_out_buf.sv
// Scoreboard bench for neuron_spike_out_buf at default parameters (DEPTH=4, 256 neurons).

module tb_neuron_spike_out_buf;
  localparam int          NN    = 256;
  localparam int          DEPTH = 4;
  localparam int          NW    = NN / 32;
  localparam logic [31:0] BASE  = 32'h30008000;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0;
  logic          wbs_stb_i = 1'b0;
  logic          wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'hF;
  logic [31:0]   wbs_adr_i = 32'h0;
  logic [31:0]   wbs_dat_i = 32'h0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          spike_valid_i = 1'b0;
  logic [NN-1:0] spike_data_i = '0;
  logic          spike_ready_o;
`ifdef SPIKE_OUT_IRQ_EN
  logic          irq_o;
`endif

  neuron_spike_out_buf #(
    .BASE_ADDR   (BASE),
    .NUM_NEURONS (NN),
    .DEPTH       (DEPTH)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .spike_valid_i (spike_valid_i),
    .spike_data_i  (spike_data_i),
    .spike_ready_o (spike_ready_o)
`ifdef SPIKE_OUT_IRQ_EN
    ,
    .irq_o         (irq_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [NN-1:0] m_frames[$];
  int          m_drop = 0;
  bit          m_ovf = 1'b0;
  logic [NN-1:0] fr[6];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n = m_frames.size();
    logic [31:0] d = 32'(m_drop);
    logic [31:0] c = 32'(n);
    return {d[15:0], 5'b0, m_ovf, (n == DEPTH), (n == 0), c[7:0]};
  endfunction

  function automatic logic [31:0] exp_ready();
    return 32'(m_frames.size() < DEPTH);
  endfunction

  task automatic model_spike(input logic [NN-1:0] f);
    if (m_frames.size() < DEPTH) m_frames.push_back(f);
    else begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic model_reset();
    m_frames.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input string tag,
                         input bit with_spike, input logic [NN-1:0] frame);
    int   cyc_n = 0;
    logic seen  = 1'b0;
    logic [31:0] exp;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    if (with_spike) begin
      spike_valid_i = 1'b1;
      spike_data_i  = frame;
    end
    while (!seen && cyc_n < 16) begin
      @(posedge wb_clk_i); #1;
      cyc_n++;
      spike_valid_i = 1'b0;
      seen = wbs_ack_o;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check_val({tag, "_acklat"}, 32'(cyc_n), 32'd1);
    if (!we) begin
      exp = exp_q.pop_front();
      check_val(tag, wbs_dat_o, exp);
    end
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    exp_q.push_back(exp);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, tag, 1'b0, '0);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    wb_xfer(1'b1, adr, dat, sel, tag, 1'b0, '0);
  endtask

  task automatic push_frame(input logic [NN-1:0] f);
    @(posedge wb_clk_i); #1;
    spike_valid_i = 1'b1;
    spike_data_i  = f;
    @(posedge wb_clk_i); #1;
    spike_valid_i = 1'b0;
    model_spike(f);
  endtask

  task automatic read_head(input string tag);
    logic [NN-1:0] head = (m_frames.size() != 0) ? m_frames[0] : '0;
    for (int k = 0; k < NW; k++)
      wb_read(tag, BASE + 32'h8 + 32'(4 * k), head[32*k +: 32]);
  endtask

  task automatic pop_head(input logic [31:0] keep);
    wb_write("pop", BASE + 32'h4, keep | 32'h1, 4'hF);
    if (m_frames.size() != 0) void'(m_frames.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < NW; k++) fr[i][32*k +: 32] = $urandom();

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    model_reset();
    check_val("rst_ack", 32'(wbs_ack_o), 32'd0);
    check_val("rst_dat", wbs_dat_o, 32'h0);
    check_val("rst_ready", 32'(spike_ready_o), 32'd1);
    wb_read("status_empty", BASE, 32'h00000100);
    wb_read("frame_empty", BASE + 32'h8, 32'h0);

    // Single frame, word read, pop
    fr[0][31:0]    = 32'hA5A5A5A5;
    fr[0][255:224] = 32'h00000001;
    push_frame(fr[0]);
    wb_read("status_one", BASE, 32'h00000001);
    wb_read("word0", BASE + 32'h08, 32'hA5A5A5A5);
    wb_read("word7", BASE + 32'h24, 32'h00000001);
    read_head("frame1");
    pop_head(32'h0);
    wb_read("status_popped", BASE, exp_status());

    // Back-to-back acks alternate
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE; wbs_we_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check_val("b2b_acks", 32'(acks), 32'd3);

    // Overfill: 6 frames back-to-back into DEPTH 4
    @(posedge wb_clk_i); #1;
    for (int i = 0; i < 6; i++) begin
      spike_valid_i = 1'b1;
      spike_data_i  = fr[i];
      @(posedge wb_clk_i); #1;
      model_spike(fr[i]);
      check_val("ready_fill", 32'(spike_ready_o), exp_ready());
    end
    spike_valid_i = 1'b0;
    wb_read("status_ovf", BASE, 32'h00020604);
    wb_write("clear", BASE + 32'h4, 32'h2, 4'hF);
    m_ovf = 1'b0; m_drop = 0;
    wb_read("status_clr", BASE, 32'h00000204);

    // Pop and drop on the same edge while full
    wb_xfer(1'b1, BASE + 32'h4, 32'h1, 4'hF, "pop_drop", 1'b1, fr[5]);
    model_spike(fr[5]);
    void'(m_frames.pop_front());
    wb_read("status_popdrop", BASE, 32'h00010403);
    push_frame(fr[4]);
    wb_read("status_refill", BASE, exp_status());
    check_val("ready_refill", 32'(spike_ready_o), exp_ready());
    for (int i = 0; i < DEPTH; i++) begin
      read_head("drain");
      pop_head(32'h0);
    end
    wb_read("status_drained", BASE, exp_status());
    wb_read("frame_drained", BASE + 32'h8, 32'h0);

    // Unmapped offset, masked CTRL write, RO STATUS write
    push_frame(fr[2]);
    wb_read("unmapped", BASE + 32'h100, 32'h0);
    wb_write("ctrl_nosel", BASE + 32'h4, 32'h7, 4'b1110);
    wb_write("status_wr", BASE, 32'hFFFFFFFF, 4'hF);
    wb_read("status_same", BASE, exp_status());
    wb_read("ctrl_same", BASE + 32'h4, 32'h0);

    // Reset with a request pending
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check_val("rst_pend_ack0", 32'(wbs_ack_o), 32'd0);
    @(posedge wb_clk_i); #1;
    check_val("rst_pend_ack1", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wb_rst_i = 1'b0;
    model_reset();
    wb_read("status_after_rst", BASE, 32'h00000100);
    check_val("ready_after_rst", 32'(spike_ready_o), 32'd1);

`ifdef SPIKE_OUT_IRQ_EN
    wb_write("irq_en", BASE + 32'h4, 32'h4, 4'hF);
    wb_read("ctrl_irq", BASE + 32'h4, 32'h4);
    check_val("irq_idle", 32'(irq_o), 32'd0);
    push_frame(fr[1]);
    check_val("irq_push_edge", 32'(irq_o), 32'd0);
    @(posedge wb_clk_i); #1;
    check_val("irq_set", 32'(irq_o), 32'd1);
    pop_head(32'h4);
    @(posedge wb_clk_i); #1;
    check_val("irq_clear", 32'(irq_o), 32'd0);
`else
    wb_write("irq_en", BASE + 32'h4, 32'h4, 4'hF);
    wb_read("ctrl_noirq", BASE + 32'h4, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
